// File: rtl/throw_scheduler_if.sv
// Bus between pattern/config registers, the throw scheduler and the trajectory side.
interface throw_scheduler_if #(
  parameter int unsigned CYC_W = 15,
  parameter int unsigned T_W   = 32
);
  // Pattern / configuration side
  logic [7:0][2:0]  pattern;
  logic [2:0]       pattern_len;
  logic [2:0]       num_balls;
  logic             pattern_valid;
  logic [CYC_W-1:0] cyc_per_beat;
  logic             run_en;

  // Throw event side
  logic             throw_valid;
  logic [2:0]       throw_ball;
  logic [2:0]       throw_height;
  logic             throw_hand;
  logic [T_W-1:0]   throw_time;
  logic [2:0]       beat_idx;
  logic             running;
  logic             sched_err;

  modport master (
    output pattern, pattern_len, num_balls, pattern_valid, cyc_per_beat, run_en,
    input  throw_valid, throw_ball, throw_height, throw_hand, throw_time,
           beat_idx, running, sched_err
  );

  modport slave (
    input  pattern, pattern_len, num_balls, pattern_valid, cyc_per_beat, run_en,
    output throw_valid, throw_ball, throw_height, throw_hand, throw_time,
           beat_idx, running, sched_err
  );
endinterface

// File: rtl/throw_scheduler.sv
// throw_scheduler: beat-level siteswap sequencer driving the trajectory datapath.
// Keeps an NSLOT-deep landing queue (slot i = ball landing i beats from now)
// and issues one registered throw event per beat.
// Build option: define SCHED_COLLISION_CHECK_EN to detect empty-hand throws,
// dropped balls and landing collisions; a detected fault parks the FSM in ERROR.
module throw_scheduler #(
  parameter int unsigned CYC_W = 15,
  parameter int unsigned T_W   = 32,
  parameter int unsigned NSLOT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  throw_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t state, state_n;

  // Sampled pattern copy
  logic [NSLOT-1:0][IDX_W-1:0] pat_q, pat_n;
  logic [IDX_W-1:0]            len_q, len_n;
  logic [IDX_W-1:0]            nb_q, nb_n;

  // Landing queue
  logic [NSLOT-1:0]            qv, qv_n;
  logic [NSLOT-1:0][IDX_W-1:0] qid, qid_n;

  // Sequencing state
  logic [IDX_W-1:0]            pidx, pidx_n;
  logic                        hand, hand_n;
  logic [CYC_W-1:0]            cnt, cnt_n;
  logic [T_W-1:0]              t, t_n;

  // Registered outputs
  logic                        tv_q, tv_n;
  logic [IDX_W-1:0]            tball_q, tball_n;
  logic [IDX_W-1:0]            theight_q, theight_n;
  logic                        thand_q, thand_n;
  logic [T_W-1:0]              ttime_q, ttime_n;
  logic [IDX_W-1:0]            bidx_q, bidx_n;
  logic                        run_q, run_n;
  logic                        err_q, err_n;

  // Beat-level helpers
  logic [IDX_W-1:0]            h;
  logic [IDX_W-1:0]            h_m1;
  logic [IDX_W-1:0]            nb_eff;
  logic [CYC_W-1:0]            cpb_eff;
  logic                        fault_c;

  assign h       = pat_q[pidx];
  assign h_m1    = h - IDX_W'(1);
  assign nb_eff  = (nb_q == '0) ? IDX_W'(1) : nb_q;
  assign cpb_eff = (bus.cyc_per_beat == '0) ? CYC_W'(1) : bus.cyc_per_beat;

  // Fault classification for the current beat (old queue contents)
`ifdef SCHED_COLLISION_CHECK_EN
  assign fault_c = ((h != '0) && !qv[0]) ||
                   ((h == '0) &&  qv[0]) ||
                   ((h != '0) &&  qv[h]);
`else
  assign fault_c = 1'b0;
`endif

  // Next-state, queue and output computation
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    len_n     = len_q;
    nb_n      = nb_q;
    qv_n      = qv;
    qid_n     = qid;
    pidx_n    = pidx;
    hand_n    = hand;
    cnt_n     = cnt;
    t_n       = t;
    tv_n      = 1'b0;
    tball_n   = tball_q;
    theight_n = theight_q;
    thand_n   = thand_q;
    ttime_n   = ttime_q;
    bidx_n    = bidx_q;

    case (state)
      S_IDLE, S_ERROR: begin
        if (bus.pattern_valid) begin
          state_n   = S_LOAD;
          pat_n     = bus.pattern;
          len_n     = bus.pattern_len;
          nb_n      = bus.num_balls;
          tball_n   = '0;
          theight_n = '0;
          thand_n   = 1'b0;
          ttime_n   = '0;
          bidx_n    = '0;
        end
      end

      S_LOAD: begin
        for (int i = 0; i < int'(NSLOT); i++) begin
          qv_n[i]  = (i < int'(nb_eff));
          qid_n[i] = IDX_W'(i);
        end
        pidx_n  = '0;
        hand_n  = 1'b0;
        cnt_n   = '0;
        state_n = S_RUN;
      end

      S_RUN: begin
        if (bus.run_en) begin
          t_n = t + T_W'(1);
        end
        if (bus.pattern_valid) begin
          // Restart takes priority over a beat in the same cycle
          state_n   = S_LOAD;
          pat_n     = bus.pattern;
          len_n     = bus.pattern_len;
          nb_n      = bus.num_balls;
          tball_n   = '0;
          theight_n = '0;
          thand_n   = 1'b0;
          ttime_n   = '0;
          bidx_n    = '0;
        end else if (bus.run_en) begin
          cnt_n = (cnt >= cpb_eff - CYC_W'(1)) ? '0 : cnt + CYC_W'(1);
          if (cnt == '0) begin
            if (fault_c) begin
              state_n = S_ERROR;
            end else begin
              for (int i = 0; i < int'(NSLOT) - 1; i++) begin
                qv_n[i]  = qv[i+1];
                qid_n[i] = qid[i+1];
              end
              qv_n[NSLOT-1]  = 1'b0;
              qid_n[NSLOT-1] = '0;
              if ((h != '0) && qv[0]) begin
                qv_n[h_m1]  = 1'b1;
                qid_n[h_m1] = qid[0];
                tv_n        = 1'b1;
                tball_n     = qid[0];
                theight_n   = h;
                thand_n     = hand;
                ttime_n     = t;
              end
              bidx_n = pidx;
              pidx_n = (pidx == len_q) ? '0 : pidx + IDX_W'(1);
              hand_n = ~hand;
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    run_n = (state_n == S_RUN);
`ifdef SCHED_COLLISION_CHECK_EN
    err_n = (state_n == S_ERROR);
`else
    err_n = 1'b0;
`endif
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      nb_q      <= '0;
      qv        <= '0;
      qid       <= '0;
      pidx      <= '0;
      hand      <= 1'b0;
      cnt       <= '0;
      t         <= '0;
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      len_q     <= len_n;
      nb_q      <= nb_n;
      qv        <= qv_n;
      qid       <= qid_n;
      pidx      <= pidx_n;
      hand      <= hand_n;
      cnt       <= cnt_n;
      t         <= t_n;
    end
  end

  // Output registers, synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tv_q      <= 1'b0;
      tball_q   <= '0;
      theight_q <= '0;
      thand_q   <= 1'b0;
      ttime_q   <= '0;
      bidx_q    <= '0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tv_q      <= tv_n;
      tball_q   <= tball_n;
      theight_q <= theight_n;
      thand_q   <= thand_n;
      ttime_q   <= ttime_n;
      bidx_q    <= bidx_n;
      run_q     <= run_n;
      err_q     <= err_n;
    end
  end

  assign bus.throw_valid  = tv_q;
  assign bus.throw_ball   = tball_q;
  assign bus.throw_height = theight_q;
  assign bus.throw_hand   = thand_q;
  assign bus.throw_time   = ttime_q;
  assign bus.beat_idx     = bidx_q;
  assign bus.running      = run_q;
  assign bus.sched_err    = err_q;

endmodule

// File: tb/tb_throw_scheduler.sv
// Self-checking bench for throw_scheduler: per-ball landing-beat model,
// directed siteswap scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_throw_scheduler;
  localparam int unsigned CYC_W = 15;
  localparam int unsigned T_W   = 32;
`ifdef SCHED_COLLISION_CHECK_EN
  localparam bit CHECK   = 1'b1;
  localparam int EXP_ERR = 1;
  localparam int EXP_RUN = 0;
`else
  localparam bit CHECK   = 1'b0;
  localparam int EXP_ERR = 0;
  localparam int EXP_RUN = 1;
`endif

  logic clk_in = 1'b0;
  logic rst_in;

  throw_scheduler_if #(.CYC_W(CYC_W), .T_W(T_W)) bus ();

  throw_scheduler #(.CYC_W(CYC_W), .T_W(T_W), .NSLOT(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each ball remembers the absolute beat it lands on (-1 = out of play)
  int     m_st;            // 0 idle, 1 load, 2 run, 3 error
  int     m_beat;
  int     land[8];
  int     m_pat[8];
  int     m_len, m_nb, m_pidx, m_hand, m_cnt;
  longint m_t;
  int     e_tv, e_ball, e_h, e_hand, e_bidx, e_run, e_err;
  longint e_time;

  int     m_log_ball[$];
  longint m_log_time[$];
  int     d_log_ball[$], d_log_hand[$], d_log_bidx[$];
  longint d_log_time[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ball_at(input int beat);
    for (int b = 0; b < 8; b++) if (land[b] == beat) return b;
    return -1;
  endfunction

  task automatic clear_outs();
    e_tv = 0; e_ball = 0; e_h = 0; e_hand = 0; e_time = 0; e_bidx = 0;
  endtask

  task automatic sample();
    for (int i = 0; i < 8; i++) m_pat[i] = int'(bus.pattern[i]);
    m_len = int'(bus.pattern_len);
    m_nb  = (bus.num_balls == 3'd0) ? 1 : int'(bus.num_balls);
  endtask

  // Predict the outputs after the coming clock edge from the current inputs
  task automatic model_step();
    int ns, h, b0, bh, cpbe;
    bit fault;
    longint t0;
    if (rst_in) begin
      m_st = 0; m_t = 0; m_cnt = 0; m_pidx = 0; m_hand = 0; m_beat = 0;
      for (int b = 0; b < 8; b++) land[b] = -1;
      clear_outs(); e_run = 0; e_err = 0;
      return;
    end
    e_tv = 0;
    ns = m_st;
    t0 = m_t;
    case (m_st)
      0, 3: if (bus.pattern_valid) begin sample(); ns = 1; clear_outs(); end
      1: begin
        for (int b = 0; b < 8; b++) land[b] = (b < m_nb) ? b : -1;
        m_beat = 0; m_pidx = 0; m_hand = 0; m_cnt = 0; ns = 2;
      end
      default: begin
        if (bus.run_en) m_t++;
        if (bus.pattern_valid) begin
          sample(); ns = 1; clear_outs();
        end else if (bus.run_en) begin
          cpbe = (bus.cyc_per_beat == '0) ? 1 : int'(bus.cyc_per_beat);
          if (m_cnt == 0) begin
            h  = m_pat[m_pidx];
            b0 = ball_at(m_beat);
            bh = (h != 0) ? ball_at(m_beat + h) : -1;
            fault = CHECK && ((h != 0 && b0 < 0) || (h == 0 && b0 >= 0) || (h != 0 && bh >= 0));
            if (fault) begin
              ns = 3;
            end else begin
              if (h == 0 && b0 >= 0) land[b0] = -1;
              if (h != 0 && b0 >= 0) begin
                if (bh >= 0) land[bh] = -1;
                land[b0] = m_beat + h;
                e_tv = 1; e_ball = b0; e_h = h; e_hand = m_hand; e_time = t0;
                m_log_ball.push_back(b0);
                m_log_time.push_back(t0);
              end
              e_bidx = m_pidx;
              m_pidx = (m_pidx == m_len) ? 0 : m_pidx + 1;
              m_hand ^= 1;
              m_beat++;
            end
          end
          m_cnt = (m_cnt >= cpbe - 1) ? 0 : m_cnt + 1;
        end
      end
    endcase
    m_st  = ns;
    e_run = (ns == 2) ? 1 : 0;
    e_err = (CHECK && ns == 3) ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("throw_valid",  bus.throw_valid,  e_tv);
    chk("throw_ball",   bus.throw_ball,   e_ball);
    chk("throw_height", bus.throw_height, e_h);
    chk("throw_hand",   bus.throw_hand,   e_hand);
    chk("throw_time",   bus.throw_time,   e_time);
    chk("beat_idx",     bus.beat_idx,     e_bidx);
    chk("running",      bus.running,      e_run);
    chk("sched_err",    bus.sched_err,    e_err);
    if (bus.throw_valid === 1'b1) begin
      d_log_ball.push_back(int'(bus.throw_ball));
      d_log_hand.push_back(int'(bus.throw_hand));
      d_log_bidx.push_back(int'(bus.beat_idx));
      d_log_time.push_back(longint'(bus.throw_time));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    m_log_ball.delete(); m_log_time.delete();
    d_log_ball.delete(); d_log_hand.delete(); d_log_bidx.delete(); d_log_time.delete();
  endtask

  function automatic logic [7:0][2:0] mkpat(input int a, input int b, input int c);
    logic [7:0][2:0] p;
    p = '0;
    p[0] = 3'(a); p[1] = 3'(b); p[2] = 3'(c);
    return p;
  endfunction

  task automatic load(input logic [7:0][2:0] p, input int len, input int nb, input int cpb);
    bus.pattern       = p;
    bus.pattern_len   = 3'(len);
    bus.num_balls     = 3'(nb);
    bus.cyc_per_beat  = CYC_W'(cpb);
    bus.pattern_valid = 1'b1;
    cycle();
    bus.pattern_valid = 1'b0;
  endtask

  initial begin
    int exp_ball1[7]  = '{0, 1, 2, 0, 1, 2, 0};
    int exp_hand1[6]  = '{0, 1, 0, 1, 0, 1};
    int exp_ball2[12] = '{0, 1, 2, 2, 1, 0, 0, 1, 2, 2, 1, 0};
    int exp_bidx2[6]  = '{0, 1, 2, 0, 1, 2};
    int waited;
    int ncyc, sel, pl;
    logic [7:0][2:0] rp;

    rst_in = 1'b1;
    bus.pattern = '0; bus.pattern_len = '0; bus.num_balls = '0;
    bus.pattern_valid = 1'b0; bus.cyc_per_beat = '0; bus.run_en = 1'b1;
    m_st = 0; m_t = 0; m_cnt = 0; m_pidx = 0; m_hand = 0; m_beat = 0;
    m_len = 0; m_nb = 1;
    for (int b = 0; b < 8; b++) begin land[b] = -1; m_pat[b] = 0; end
    clear_outs(); e_run = 0; e_err = 0;

    // Reset
    run(3);
    chk("reset_running", bus.running, 0);
    chk("reset_valid", bus.throw_valid, 0);
    rst_in = 1'b0;
    run(2);

    // Cascade 3, three balls, four clocks per beat
    clear_logs();
    load(mkpat(3, 0, 0), 0, 3, 4);
    run(22);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("c1_ball%0d", i), (i < d_log_ball.size()) ? d_log_ball[i] : -1, exp_ball1[i]);
      chk($sformatf("c1_hand%0d", i), (i < d_log_hand.size()) ? d_log_hand[i] : -1, exp_hand1[i]);
      chk($sformatf("c1_time%0d", i), (i < d_log_time.size()) ? d_log_time[i] : -1, 4 * i);
      chk($sformatf("c1_model_ball%0d", i), (i < m_log_ball.size()) ? m_log_ball[i] : -1, exp_ball1[i]);
      chk($sformatf("c1_model_time%0d", i), (i < m_log_time.size()) ? m_log_time[i] : -1, 4 * i);
    end

    // Pause mid-beat: the timestamp freezes so spacing stays four
    run(2);
    bus.run_en = 1'b0;
    run(10);
    chk("c5_no_throw_in_pause", d_log_ball.size(), 6);
    bus.run_en = 1'b1;
    run(12);
    chk("c5_time6", (d_log_time.size() > 6) ? d_log_time[6] : -1, 24);
    chk("c5_ball6", (d_log_ball.size() > 6) ? d_log_ball[6] : -1, exp_ball1[6]);
    chk("c5_time7", (d_log_time.size() > 7) ? d_log_time[7] : -1, 28);

    // Restart strobe exactly on a beat cycle
    waited = 0;
    while (!(m_st == 2 && m_cnt == 0)) begin
      if (waited++ > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL c6_wait_beat: got no beat cycle, want one within 20 cycles");
        break;
      end
      cycle();
    end
    load(mkpat(3, 0, 0), 0, 3, 4);
    chk("c6_restart_valid", bus.throw_valid, 0);
    chk("c6_restart_running", bus.running, 0);
    chk("c6_restart_bidx", bus.beat_idx, 0);
    run(8);

    // Synchronous reset while running
    rst_in = 1'b1;
    cycle();
    chk("c6_rst_valid", bus.throw_valid, 0);
    chk("c6_rst_running", bus.running, 0);
    chk("c6_rst_time", bus.throw_time, 0);
    chk("c6_rst_ball", bus.throw_ball, 0);
    rst_in = 1'b0;
    run(2);

    // 5-3-1, one clock per beat (cyc_per_beat = 0 counts as 1)
    load(mkpat(5, 3, 1), 2, 3, 0);
    clear_logs();
    run(16);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("c2_ball%0d", i), (i < d_log_ball.size()) ? d_log_ball[i] : -1, exp_ball2[i]);
      chk($sformatf("c2_model_ball%0d", i), (i < m_log_ball.size()) ? m_log_ball[i] : -1, exp_ball2[i]);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("c2_bidx%0d", i), (i < d_log_bidx.size()) ? d_log_bidx[i] : -1, exp_bidx2[i]);

    // 4-4-0 with three balls drops a ball on beat 2
    load(mkpat(4, 4, 0), 2, 3, 2);
    run(14);
    chk("c3_sched_err", bus.sched_err, EXP_ERR);
    chk("c3_running", bus.running, EXP_RUN);

    // 3-2-1 with two balls collides on beat 1; a new strobe recovers
    load(mkpat(3, 2, 1), 2, 2, 1);
    run(6);
    chk("c4_sched_err", bus.sched_err, EXP_ERR);
    load(mkpat(3, 0, 0), 0, 3, 2);
    chk("c4_err_cleared", bus.sched_err, 0);
    run(6);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: load(mkpat(4, 2, 3), 2, 3, int'($urandom_range(0, 3)));
        1: load(mkpat(5, 0, 1), 2, 2, int'($urandom_range(0, 3)));
        default: begin
          rp = '0;
          for (int i = 0; i < 8; i++) rp[i] = 3'($urandom_range(0, 7));
          pl = int'($urandom_range(0, 7));
          load(rp, pl, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
      endcase
      ncyc = int'($urandom_range(20, 80));
      for (int c = 0; c < ncyc; c++) begin
        bus.run_en = ($urandom_range(0, 99) < 85);
        for (int i = 0; i < 8; i++) bus.pattern[i] = 3'($urandom_range(0, 7));
        bus.pattern_len   = 3'($urandom_range(0, 7));
        bus.num_balls     = 3'($urandom_range(0, 7));
        bus.pattern_valid = ($urandom_range(0, 99) < 2);
        rst_in            = ($urandom_range(0, 199) == 0);
        cycle();
      end
      bus.pattern_valid = 1'b0;
      rst_in = 1'b0;
      bus.run_en = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
